// File: rtl/sevenseg_scanner.sv
// Six-digit time-multiplexed 7-segment driver with time/date/weekday pages,
// a once-per-frame input snapshot, inter-digit blanking and set-mode blink.
module sevenseg_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK        = 8,
    parameter int HOLD_FRAMES  = 1000,
    parameter int BLINK_FRAMES = 42
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] time_bcd,
    input  logic [23:0] date_bcd,
    input  logic [2:0]  weekday,
    input  logic        pm,
    input  logic        fmt12,
    input  logic [1:0]  clk_mode,
    input  logic        view,
    output logic [5:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(HOLD_FRAMES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    // Non-BCD codes used only inside the weekday page word.
    localparam logic [3:0] NIB_DASH  = 4'hE;
    localparam logic [3:0] NIB_BLANK = 4'hF;

    typedef enum logic [1:0] {
        P_TIME = 2'd0,
        P_DATE = 2'd1,
        P_WDAY = 2'd2
    } page_t;

    logic [PW-1:0] r_presc;
    logic [2:0]    r_slot;
    page_t         r_page;
    logic [HW-1:0] r_hold;
    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;
    logic          r_view_pend;
    logic [23:0]   r_snap;
    logic          r_fmt12;
    logic          r_pm;
    logic          r_blank;
    logic [5:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_presc_wrap;
    logic          w_frame_start;
    logic          w_view;
    page_t         w_page_next;
    logic [HW-1:0] w_hold_next;
    logic [HW-1:0] w_hold_inc;
    logic [3:0]    w_wday_digit;
    logic [23:0]   w_word_next;
    logic          w_phase_next;
    logic [3:0]    w_nib;
    logic [6:0]    w_seg;
    logic          w_dp;
    logic          w_dark;
    logic [5:0]    w_an_sel;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    f_decode = 7'h40;
            4'd1:    f_decode = 7'h79;
            4'd2:    f_decode = 7'h24;
            4'd3:    f_decode = 7'h30;
            4'd4:    f_decode = 7'h19;
            4'd5:    f_decode = 7'h12;
            4'd6:    f_decode = 7'h02;
            4'd7:    f_decode = 7'h78;
            4'd8:    f_decode = 7'h00;
            4'd9:    f_decode = 7'h10;
            default: f_decode = 7'h3F;
        endcase
    endfunction

    assign w_presc_wrap  = (r_presc == PRESC_LAST);
    assign w_frame_start = w_presc_wrap && (r_slot == 3'd5);
    assign w_view        = r_view_pend | view;
    assign w_hold_inc    = r_hold + 1'b1;
    assign w_wday_digit  = {1'b0, weekday} + 4'd1;
    assign w_phase_next  = r_phase ^ (r_blink_cnt == BLINK_LAST);

    // Page decision for the coming frame; only registered at frame start.
    always_comb begin
        w_page_next = r_page;
        w_hold_next = r_hold;
        if (clk_mode == 2'b01) begin
            w_page_next = P_TIME;
            w_hold_next = '0;
        end else if (clk_mode == 2'b11) begin
            w_page_next = P_DATE;
            w_hold_next = '0;
        end else if (w_view) begin
            w_hold_next = '0;
            case (r_page)
                P_TIME:  w_page_next = P_DATE;
                P_DATE:  w_page_next = P_WDAY;
                default: w_page_next = P_TIME;
            endcase
        end else if (r_page != P_TIME) begin
            if (w_hold_inc == HOLD_LIMIT) begin
                w_page_next = P_TIME;
                w_hold_next = '0;
            end else begin
                w_hold_next = w_hold_inc;
            end
        end
    end

    always_comb begin
        w_word_next = time_bcd;
        case (w_page_next)
            P_DATE:  w_word_next = date_bcd;
            P_WDAY:  w_word_next = {NIB_BLANK, NIB_BLANK, NIB_DASH,
                                    w_wday_digit, NIB_DASH, NIB_BLANK};
            default: w_word_next = time_bcd;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_slot  <= '0;
        end else begin
            r_presc <= w_presc_wrap ? '0 : r_presc + 1'b1;
            if (w_presc_wrap)
                r_slot <= (r_slot == 3'd5) ? 3'd0 : r_slot + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_page      <= P_TIME;
            r_hold      <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_view_pend <= 1'b0;
            r_snap      <= '0;
            r_fmt12     <= 1'b0;
            r_pm        <= 1'b0;
            r_blank     <= 1'b0;
        end else if (w_frame_start) begin
            r_page      <= w_page_next;
            r_hold      <= w_hold_next;
            r_blink_cnt <= (r_blink_cnt == BLINK_LAST) ? '0 : r_blink_cnt + 1'b1;
            r_phase     <= w_phase_next;
            r_view_pend <= 1'b0;
            r_snap      <= w_word_next;
            r_fmt12     <= fmt12;
            r_pm        <= pm;
            r_blank     <= (clk_mode != 2'b00) && w_phase_next;
        end else if (view) begin
            r_view_pend <= 1'b1;
        end
    end

    assign w_nib = r_snap[{r_slot, 2'b00} +: 4];

    always_comb begin
        w_seg = f_decode(w_nib);
        if (r_page == P_WDAY && w_nib == NIB_BLANK)
            w_seg = 7'h7F;
        else if (r_page == P_TIME && r_fmt12 && r_slot == 3'd5 && w_nib == 4'd0)
            w_seg = 7'h7F;

        w_dp = 1'b1;
        if ((r_slot == 3'd2 || r_slot == 3'd4) && r_page != P_WDAY)
            w_dp = 1'b0;
        else if (r_slot == 3'd0 && r_page == P_TIME && r_fmt12 && r_pm)
            w_dp = 1'b0;
    end

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_an
            assign w_an_sel[gi] = (r_slot != 3'(gi));
        end
    endgenerate

    assign w_dark = (r_presc < BLANK_END) || r_blank;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an  <= 6'h3F;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else if (w_dark) begin
            r_an  <= 6'h3F;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_sel;
            r_seg <= w_seg;
            r_dp  <= w_dp;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Directed bench for sevenseg_scanner with a 4-cycle slot and 24-cycle frame;
// every sample point is addressed by its clock count since reset release.
module tb_sevenseg_scanner;

    localparam int FR = 24;
    localparam int SL = 4;

    logic        clk;
    logic        rst;
    logic [23:0] time_bcd;
    logic [23:0] date_bcd;
    logic [2:0]  weekday;
    logic        pm;
    logic        fmt12;
    logic [1:0]  clk_mode;
    logic        view;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int cyc;
    int n_tests;
    int n_fail;

    localparam logic [41:0] SEG_ZERO = {6{7'h40}};
    localparam logic [41:0] SEG_T123 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
    localparam logic [41:0] SEG_T091 = {7'h7F, 7'h10, 7'h79, 7'h12, 7'h40, 7'h40};
    localparam logic [41:0] SEG_T112 = {7'h79, 7'h79, 7'h24, 7'h24, 7'h30, 7'h30};
    localparam logic [41:0] SEG_T998 = {7'h10, 7'h10, 7'h00, 7'h00, 7'h78, 7'h78};
    localparam logic [41:0] SEG_DATE = {7'h30, 7'h79, 7'h79, 7'h24, 7'h3F, 7'h12};
    localparam logic [41:0] SEG_WDAY = {7'h7F, 7'h7F, 7'h3F, 7'h19, 7'h3F, 7'h7F};
    localparam logic [5:0]  DP_SEP   = 6'b101011;

    sevenseg_scanner #(
        .SCAN_DIV    (4),
        .BLANK       (1),
        .HOLD_FRAMES (3),
        .BLINK_FRAMES(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .time_bcd(time_bcd),
        .date_bcd(date_bcd),
        .weekday (weekday),
        .pm      (pm),
        .fmt12   (fmt12),
        .clk_mode(clk_mode),
        .view    (view),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic check_slot(input string tag, input int f, input int s,
                              input logic [6:0] e_seg, input logic e_dp);
        logic [5:0] e_an;
        int base;
        e_an = ~(6'b000001 << s);
        base = FR * f + SL * s;
        goto(base + 1);
        chk($sformatf("%s f%0d s%0d gap_an", tag, f, s), 32'(an), 32'h3F);
        chk($sformatf("%s f%0d s%0d gap_seg", tag, f, s), 32'(seg), 32'h7F);
        goto(base + 2);
        chk($sformatf("%s f%0d s%0d an", tag, f, s), 32'(an), 32'(e_an));
        chk($sformatf("%s f%0d s%0d seg", tag, f, s), 32'(seg), 32'(e_seg));
        chk($sformatf("%s f%0d s%0d dp", tag, f, s), 32'(dp), 32'(e_dp));
        goto(base + 3);
        chk($sformatf("%s f%0d s%0d an_end", tag, f, s), 32'(an), 32'(e_an));
    endtask

    task automatic check_frame(input string tag, input int f, input int lo, input int hi,
                               input logic [41:0] segs, input logic [5:0] dps);
        for (int s = lo; s <= hi; s++)
            check_slot(tag, f, s, segs[7*s +: 7], dps[s]);
    endtask

    task automatic check_dark(input string tag, input int f);
        for (int s = 0; s < 6; s++) begin
            goto(FR * f + SL * s + 2);
            chk($sformatf("%s f%0d s%0d an_dark", tag, f, s), 32'(an), 32'h3F);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        rst      = 1'b0;
        time_bcd = 24'h123456;
        date_bcd = 24'h3112A5;
        weekday  = 3'd3;
        pm       = 1'b0;
        fmt12    = 1'b0;
        clk_mode = 2'b00;
        view     = 1'b0;

        @(negedge clk);
        chk("rst an", 32'(an), 32'h3F);
        chk("rst seg", 32'(seg), 32'h7F);
        chk("rst dp", 32'(dp), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;

        // Frame 0 shows the all-zero reset snapshot; frame 1 the 24-h time.
        check_frame("reset_snap", 0, 0, 5, SEG_ZERO, DP_SEP);
        check_frame("scan24", 1, 0, 5, SEG_T123, DP_SEP);

        time_bcd = 24'h091500;
        fmt12    = 1'b1;
        pm       = 1'b1;
        check_frame("fmt12", 2, 0, 5, SEG_T091, 6'b101010);

        time_bcd = 24'h112233;
        fmt12    = 1'b0;
        pm       = 1'b0;
        check_frame("snap", 3, 0, 1, SEG_T112, DP_SEP);
        goto(FR * 3 + SL * 2);
        time_bcd = 24'h998877;
        check_frame("snap_hold", 3, 2, 5, SEG_T112, DP_SEP);

        check_frame("snap_new", 4, 0, 2, SEG_T998, DP_SEP);
        view = 1'b1;
        step();
        view = 1'b0;
        check_frame("view_pend", 4, 3, 5, SEG_T998, DP_SEP);

        check_frame("date", 5, 0, 0, SEG_DATE, DP_SEP);
        view = 1'b1;
        step();
        view = 1'b0;
        check_frame("date", 5, 1, 5, SEG_DATE, DP_SEP);

        check_frame("wday", 6, 0, 5, SEG_WDAY, 6'b111111);
        check_frame("wday_hold1", 7, 2, 2, SEG_WDAY, 6'b111111);
        check_frame("wday_hold2", 8, 2, 2, SEG_WDAY, 6'b111111);
        check_frame("auto_time", 9, 0, 5, SEG_T998, DP_SEP);

        // Date-set force arrives on the same edge as a view pulse.
        clk_mode = 2'b11;
        view     = 1'b1;
        step();
        view     = 1'b0;
        check_dark("force_blink", 10);
        clk_mode = 2'b00;
        check_frame("force_date", 11, 0, 5, SEG_DATE, DP_SEP);

        clk_mode = 2'b01;
        check_frame("tset_lit", 12, 0, 5, SEG_T998, DP_SEP);
        check_frame("tset_lit", 13, 0, 0, SEG_T998, DP_SEP);
        check_dark("tset_off", 14);
        check_dark("tset_off", 15);
        check_frame("tset_relit", 16, 0, 0, SEG_T998, DP_SEP);
        clk_mode = 2'b00;
        check_frame("run_noblink", 18, 0, 5, SEG_T998, DP_SEP);

        // Asynchronous reset in the middle of slot 3.
        goto(FR * 19 + SL * 3 + 2);
        chk("pre_rst an", 32'(an), 32'h37);
        rst = 1'b0;
        #1;
        chk("async_rst an", 32'(an), 32'h3F);
        chk("async_rst seg", 32'(seg), 32'h7F);
        chk("async_rst dp", 32'(dp), 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        goto(1);
        chk("rerelease c1 an", 32'(an), 32'h3F);
        goto(2);
        chk("rerelease c2 an", 32'(an), 32'h3E);
        chk("rerelease c2 seg", 32'(seg), 32'h40);
        chk("rerelease c2 dp", 32'(dp), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sevenseg_scanner.md
# sevenseg_scanner

Time-multiplexed driver for the six-digit common-anode 7-segment display. It reads the packed BCD time word from the time formatter and the packed BCD date/weekday words from the date counter, and scans them onto shared segment lines. It runs a page state machine (time / date / weekday), latches a tear-free snapshot once per frame, blanks between digits to suppress ghosting, and blinks the display while a set mode is active.

## Interface
- SCAN_DIV, 50000: clk cycles per digit slot (1 kHz slot rate at 50 MHz).
- BLANK, 8: leading cycles of each slot with all anodes off; must be < SCAN_DIV.
- HOLD_FRAMES, 1000: frames without a view pulse before DATE/WDAY returns to TIME.
- BLINK_FRAMES, 42: frames per blink half-period.
- clk  in  1  master clock.
- rst  in  1  asynchronous, active-low reset.
- time_bcd  in  24  hh_mm_ss BCD, already 12/24-h formatted.
- date_bcd  in  24  dd_mm_yy BCD.
- weekday  in  3  0..6.
- pm  in  1  1 = PM (meaningful only when fmt12=1).
- fmt12  in  1  12-hour display enable.
- clk_mode  in  2  00 run, 01 time set, 10 other, 11 date set.
- view  in  1  single-cycle, pre-debounced page-advance pulse.
- an  out  6  digit anodes, active-low; an[5] is leftmost.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
- Prescaler presc counts 0..SCAN_DIV-1 and wraps. Slot counter slot (0..5) advances on the wrap. Frame start is when slot goes 5→0.
- Slot i shows snapshot nibble [4i+3:4i] on anode an[i].
- At frame start these are registered together: the snapshot word from the current page, the page itself, the blink phase, and the hold count. Inputs never change mid-frame.
- Page FSM: states P_TIME, P_DATE, P_WDAY.
  - view pulse: TIME→DATE→WDAY→TIME, pending until the next frame start.
  - clk_mode 01 forces P_TIME. clk_mode 11 forces P_DATE. A force overrides a pending or simultaneous view pulse, and the pulse is discarded.
  - In DATE or WDAY, the hold counter increments each frame and clears on a view pulse. When it reaches HOLD_FRAMES the FSM returns to TIME.
- Page words:
  - TIME: time_bcd.
  - DATE: date_bcd.
  - WDAY: digits 5..0 = blank, blank, dash, weekday+1, dash, blank.
- Decode:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex, 7 bits).
  - Dash = 3F. Blank = 7F. Any nibble greater than 9 on TIME or DATE shows dash.
- Leading blank: on TIME with fmt12=1 and hour-tens = 0, digit 5 is blank.
- dp lit (0):
  - digits 4 and 2 on TIME and DATE (separators);
  - digit 0 on TIME when fmt12=1 and pm=1.
  - Otherwise dp = 1.
- Blink:
  - The blink counter counts frames and toggles the phase every BLINK_FRAMES frames; it always runs.
  - When clk_mode ≠ 00 and phase = off, an = 3F for the whole frame.
  - clk_mode = 00 never blanks.
- Reset (asynchronous assert, any time): presc=0, slot=0, page=P_TIME, hold=0, blink counter and phase=0 (on), snapshot=0, an=3F, seg=7F, dp=1. Operation restarts cleanly on the first clk after deassert.

## Timing
- an, seg and dp are registered and lag the slot/presc state by one clk.
- Within a slot, for presc < BLANK: an=3F and seg=7F. From presc = BLANK to the end of the slot: exactly one an bit is low, with seg/dp valid.
- Slot period is SCAN_DIV cycles. Frame is 6·SCAN_DIV cycles.
- Input-to-display latency is at most one frame plus one clk.
- A view pulse changes the displayed page at the next frame start, so at most 6·SCAN_DIV + 1 cycles later.
- Anodes never overlap; each slot transition passes through at least BLANK all-off cycles.

## Test plan
All scenarios use SCAN_DIV=4, BLANK=1, HOLD_FRAMES=3, BLINK_FRAMES=2.
- Reset mid-slot: rst low while slot=3 → an=3F, seg=7F, dp=1 immediately (before the next clk edge); after release, the first slot is slot 0 and the first lit anode is an[0] two cycles after deassert.
- Scan and decode: time_bcd=24'h123456, fmt12=0, clk_mode=00 → slots 0..5 show seg 02,12,19,30,24,79; dp=0 on slots 2 and 4 only; one all-off cycle before each digit.
- 12-hour format: time_bcd=24'h091500, fmt12=1, pm=1 → digit 5 blank (7F), digit 4 seg=10, dp=0 on digit 0.
- Tear-free snapshot: change time_bcd mid-frame at slot 2 → rest of frame shows the old value; new value appears from the next slot 0.
- Page FSM and auto-return: view pulse → DATE from next frame; view → WDAY with weekday=3 showing 7F,7F,3F,19,3F,7F; no further pulses → TIME after 3 frames. clk_mode=11 with a simultaneous view pulse → DATE, pulse ignored.
- Blink: clk_mode=01 → 2 frames lit, 2 frames all an=3F, repeating; page forced to TIME. clk_mode=00 → never blanked.
